// File: rtl/gobou_fc_ctrl_pkg.sv
// Shared defaults and state encoding for the gobou fully-connected sequencer.
package gobou_fc_ctrl_pkg;

    localparam int DEF_CORE    = 16;
    localparam int DEF_CORELOG = 4;
    localparam int DEF_DWIDTH  = 16;
    localparam int DEF_LWIDTH  = 10;
    localparam int DEF_BWIDTH  = 4;
    localparam int DEF_IMGSIZE = 12;
    localparam int DEF_NETSIZE = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WEIGHT,
        S_BIAS,
        S_WAIT_RES,
        S_OUTPUT
    } gobou_fc_state_t;

endpackage

// File: rtl/gobou_fc_ctrl_if.sv
// Layer-level control bundle: start/done handshake plus the per-layer job description.
interface gobou_fc_ctrl_if #(
    parameter int LWIDTH  = gobou_fc_ctrl_pkg::DEF_LWIDTH,
    parameter int BWIDTH  = gobou_fc_ctrl_pkg::DEF_BWIDTH,
    parameter int IMGSIZE = gobou_fc_ctrl_pkg::DEF_IMGSIZE,
    parameter int NETSIZE = gobou_fc_ctrl_pkg::DEF_NETSIZE
);
    logic               req;
    logic               ack;
    logic               bias_en;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  total_out;
    logic [BWIDTH-1:0]  batch;
    logic [IMGSIZE-1:0] in_offset;
    logic [IMGSIZE-1:0] out_offset;
    logic [NETSIZE-1:0] net_offset;

    modport master (output req, bias_en, total_in, total_out, batch,
                           in_offset, out_offset, net_offset,
                    input  ack);
    modport slave  (input  req, bias_en, total_in, total_out, batch,
                           in_offset, out_offset, net_offset,
                    output ack);
endinterface

// File: rtl/gobou_fc_serial_cnt.sv
// Serialiser position counter (1..CORE) and the img_we window covering the valid outputs.
// Latency: img_we registered, high the cycle after serial_we; no backpressure.
module gobou_fc_serial_cnt
    import gobou_fc_ctrl_pkg::*;
#(
    parameter int CORE    = DEF_CORE,
    parameter int CORELOG = DEF_CORELOG,
    parameter int LWIDTH  = DEF_LWIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serial_we,
    input  logic [LWIDTH-1:0]  rem,
    output logic [CORELOG:0]   cnt_nxt,
    output logic               wr_nxt,
    output logic               done,
    output logic               img_we
);
    localparam logic [CORELOG:0] CNT_ONE = (CORELOG+1)'(1);
    localparam logic [CORELOG:0] CNT_MAX = (CORELOG+1)'(CORE);

    logic [CORELOG:0] cnt_q, cnt_d, n_valid;
    logic             img_we_q, img_we_d;

    always_comb begin
        // rem below CORE always fits in the counter width
        n_valid  = (rem >= LWIDTH'(CORE)) ? CNT_MAX : rem[CORELOG:0];
        cnt_d    = '0;
        if (serial_we)
            cnt_d = CNT_ONE;
        else if (cnt_q != '0 && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_ONE;
        img_we_d = (cnt_d != '0) && (cnt_d <= n_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            img_we_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            img_we_q <= img_we_d;
        end
    end

    assign cnt_nxt = cnt_d;
    assign wr_nxt  = img_we_d;
    assign done    = (cnt_q == CNT_MAX);
    assign img_we  = img_we_q;

endmodule

// File: rtl/gobou_fc_ctrl.sv
// Fully-connected layer sequencer: weight/bias phases per group, batch reuse, partial last group.
// Latency: all controls registered one cycle behind the state; waits only on res_start.
module gobou_fc_ctrl
    import gobou_fc_ctrl_pkg::*;
#(
    parameter int CORE    = DEF_CORE,
    parameter int CORELOG = DEF_CORELOG,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int LWIDTH  = DEF_LWIDTH,
    parameter int BWIDTH  = DEF_BWIDTH,
    parameter int IMGSIZE = DEF_IMGSIZE,
    parameter int NETSIZE = DEF_NETSIZE
) (
    input  logic               clk,
    input  logic               rst,
    gobou_fc_ctrl_if.slave     ctl,
    input  logic               net_we,
    input  logic [CORELOG-1:0] net_sel,
    input  logic [NETSIZE-1:0] net_addr,
    input  logic               res_start,
    input  logic [DWIDTH-1:0]  out_wdata,
    output logic               core_start,
    output logic               core_valid,
    output logic               core_stop,
    output logic               img_we,
    output logic [IMGSIZE-1:0] img_addr,
    output logic [DWIDTH-1:0]  img_wdata,
    output logic [CORE-1:0]    mem_net_we,
    output logic [NETSIZE-1:0] mem_net_addr,
    output logic               breg_we,
    output logic               serial_we
);
    gobou_fc_state_t    state_q, state_d;
    logic               ack_q, ack_d, core_start_q, core_start_d, core_valid_q, core_valid_d;
    logic               core_stop_q, core_stop_d, breg_we_q, breg_we_d, serial_we_q, serial_we_d;
    logic               bias_en_q, bias_en_d;
    logic [LWIDTH-1:0]  total_in_q, total_in_d, total_out_q, total_out_d;
    logic [LWIDTH-1:0]  rem_q, rem_d, i_q, i_d;
    logic [BWIDTH-1:0]  batch_q, batch_d, b_q, b_d;
    logic [IMGSIZE-1:0] img_addr_q, img_addr_d, in_off_q, in_off_d, in_base_q, in_base_d;
    logic [IMGSIZE-1:0] out_grp_q, out_grp_d, out_base_q, out_base_d;
    logic [NETSIZE-1:0] net_addr_q, net_addr_d, grp_base_q, grp_base_d;
    logic [CORELOG:0]   cnt_nxt;
    logic               wr_nxt, ser_done;

    gobou_fc_serial_cnt #(.CORE(CORE), .CORELOG(CORELOG), .LWIDTH(LWIDTH)) u_serial (
        .clk       (clk),
        .rst       (rst),
        .serial_we (serial_we_q),
        .rem       (rem_q),
        .cnt_nxt   (cnt_nxt),
        .wr_nxt    (wr_nxt),
        .done      (ser_done),
        .img_we    (img_we)
    );

    always_comb begin
        state_d      = state_q;      ack_d       = ack_q;
        core_start_d = 1'b0;         core_valid_d = 1'b0;
        core_stop_d  = 1'b0;         breg_we_d   = 1'b0;
        serial_we_d  = 1'b0;         bias_en_d   = bias_en_q;
        total_in_d   = total_in_q;   total_out_d = total_out_q;
        rem_d        = rem_q;        i_d         = i_q;
        batch_d      = batch_q;      b_d         = b_q;
        in_off_d     = in_off_q;     in_base_d   = in_base_q;
        out_grp_d    = out_grp_q;    out_base_d  = out_base_q;
        grp_base_d   = grp_base_q;
        img_addr_d   = '0;           net_addr_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                ack_d = 1'b1;
                if (ctl.req && ack_q) begin
                    ack_d        = 1'b0;
                    core_start_d = 1'b1;
                    bias_en_d    = ctl.bias_en;
                    total_in_d   = ctl.total_in;
                    total_out_d  = ctl.total_out;
                    batch_d      = ctl.batch;
                    rem_d        = ctl.total_out;
                    in_off_d     = ctl.in_offset;
                    in_base_d    = ctl.in_offset;
                    out_grp_d    = ctl.out_offset;
                    out_base_d   = ctl.out_offset;
                    grp_base_d   = ctl.net_offset;
                    i_d          = '0;
                    b_d          = '0;
                    // an empty job stays idle; ack_q low for this one cycle is the done pulse
                    if (ctl.total_in != '0 && ctl.total_out != '0 && ctl.batch != '0)
                        state_d = S_WEIGHT;
                end
            end
            S_WEIGHT: begin
                core_valid_d = 1'b1;
                img_addr_d   = in_base_q + IMGSIZE'(i_q);
                net_addr_d   = grp_base_q + NETSIZE'(i_q);
                if (i_q == total_in_q - LWIDTH'(1)) begin
                    i_d         = '0;
                    core_stop_d = !bias_en_q;
                    state_d     = bias_en_q ? S_BIAS : S_WAIT_RES;
                end else begin
                    i_d = i_q + LWIDTH'(1);
                end
            end
            S_BIAS: begin
                core_valid_d = 1'b1;
                breg_we_d    = 1'b1;
                core_stop_d  = 1'b1;
                net_addr_d   = grp_base_q + NETSIZE'(total_in_q);
                state_d      = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (serial_we_q)
                    state_d = S_OUTPUT;
                else if (res_start)
                    serial_we_d = 1'b1;
            end
            S_OUTPUT: begin
                if (ser_done) begin
                    if (b_q != batch_q - BWIDTH'(1)) begin
                        b_d          = b_q + BWIDTH'(1);
                        in_base_d    = in_base_q + IMGSIZE'(total_in_q);
                        out_base_d   = out_base_q + IMGSIZE'(total_out_q);
                        core_start_d = 1'b1;
                        state_d      = S_WEIGHT;
                    end else if (rem_q > LWIDTH'(CORE)) begin
                        b_d          = '0;
                        in_base_d    = in_off_q;
                        out_grp_d    = out_grp_q + IMGSIZE'(CORE);
                        out_base_d   = out_grp_q + IMGSIZE'(CORE);
                        grp_base_d   = grp_base_q + NETSIZE'(total_in_q) + NETSIZE'(bias_en_q);
                        rem_d        = rem_q - LWIDTH'(CORE);
                        core_start_d = 1'b1;
                        state_d      = S_WEIGHT;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // the write window opens while still in S_WAIT_RES, so address it outside the case
        if (wr_nxt)
            img_addr_d = out_base_q + IMGSIZE'(cnt_nxt) - IMGSIZE'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;  ack_q       <= 1'b1;
            core_start_q <= 1'b0;    core_valid_q <= 1'b0;
            core_stop_q  <= 1'b0;    breg_we_q   <= 1'b0;
            serial_we_q  <= 1'b0;    bias_en_q   <= 1'b0;
            total_in_q   <= '0;      total_out_q <= '0;
            rem_q        <= '0;      i_q         <= '0;
            batch_q      <= '0;      b_q         <= '0;
            in_off_q     <= '0;      in_base_q   <= '0;
            out_grp_q    <= '0;      out_base_q  <= '0;
            grp_base_q   <= '0;      img_addr_q  <= '0;
            net_addr_q   <= '0;
        end else begin
            state_q      <= state_d;      ack_q       <= ack_d;
            core_start_q <= core_start_d; core_valid_q <= core_valid_d;
            core_stop_q  <= core_stop_d;  breg_we_q   <= breg_we_d;
            serial_we_q  <= serial_we_d;  bias_en_q   <= bias_en_d;
            total_in_q   <= total_in_d;   total_out_q <= total_out_d;
            rem_q        <= rem_d;        i_q         <= i_d;
            batch_q      <= batch_d;      b_q         <= b_d;
            in_off_q     <= in_off_d;     in_base_q   <= in_base_d;
            out_grp_q    <= out_grp_d;    out_base_q  <= out_base_d;
            grp_base_q   <= grp_base_d;   img_addr_q  <= img_addr_d;
            net_addr_q   <= net_addr_d;
        end
    end

    always_comb begin
        mem_net_we = '0;
        for (int j = 0; j < CORE; j++)
            mem_net_we[j] = net_we && (net_sel == CORELOG'(j));
    end

    assign mem_net_addr = net_we ? net_addr : net_addr_q;
    assign img_wdata    = img_we ? out_wdata : '0;
    assign ctl.ack      = ack_q;
    assign core_start   = core_start_q;
    assign core_valid   = core_valid_q;
    assign core_stop    = core_stop_q;
    assign breg_we      = breg_we_q;
    assign serial_we    = serial_we_q;
    assign img_addr     = img_addr_q;

endmodule

// File: tb/tb_gobou_fc_ctrl.sv
// Directed bench for gobou_fc_ctrl: a negedge monitor logs the DUT's traffic, checks compare logs to hand-built lists.
module tb_gobou_fc_ctrl;
    import gobou_fc_ctrl_pkg::*;

    typedef logic [31:0] wq_t[$];

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   net_we;
    logic [DEF_CORELOG-1:0] net_sel;
    logic [DEF_NETSIZE-1:0] net_addr;
    logic                   res_start;
    logic [DEF_DWIDTH-1:0]  out_wdata;
    logic                   core_start, core_valid, core_stop, img_we, breg_we, serial_we;
    logic [DEF_IMGSIZE-1:0] img_addr;
    logic [DEF_DWIDTH-1:0]  img_wdata;
    logic [DEF_CORE-1:0]    mem_net_we;
    logic [DEF_NETSIZE-1:0] mem_net_addr;

    gobou_fc_ctrl_if ctl ();

    gobou_fc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ctl          (ctl),
        .net_we       (net_we),
        .net_sel      (net_sel),
        .net_addr     (net_addr),
        .res_start    (res_start),
        .out_wdata    (out_wdata),
        .core_start   (core_start),
        .core_valid   (core_valid),
        .core_stop    (core_stop),
        .img_we       (img_we),
        .img_addr     (img_addr),
        .img_wdata    (img_wdata),
        .mem_net_we   (mem_net_we),
        .mem_net_addr (mem_net_addr),
        .breg_we      (breg_we),
        .serial_we    (serial_we)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    wq_t net_log, in_log, wa_log, wd_log, wx_log, breg_idx;
    int  cv_n, cs_n, stop_n, ack_lo, wd_viol, cyc, last_we, ack_rise;
    logic ack_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_list(input string tag, input wq_t got, input wq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size(); k++)
            check(tag, (k < got.size()) ? got[k] : 32'hDEAD_BEEF, exp[k]);
    endtask

    // reps blocks of n consecutive values; block r starts at base + r*step
    function automatic wq_t ramp(input int base, input int n, input int reps, input int step);
        wq_t q;
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < n; k++)
                q.push_back(32'(base + r*step + k));
        return q;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (core_valid) begin
            cv_n++;
            if (!net_we)  net_log.push_back(32'(mem_net_addr));
            if (!breg_we) in_log.push_back(32'(img_addr));
            if (breg_we)  breg_idx.push_back(32'(cv_n));
        end
        if (core_start) cs_n++;
        if (core_stop)  stop_n++;
        if (img_we) begin
            wa_log.push_back(32'(img_addr));
            wd_log.push_back(32'(img_wdata));
            wx_log.push_back(32'(out_wdata));
            last_we = cyc;
        end else if (img_wdata != '0) begin
            wd_viol++;
        end
        if (!ctl.ack)             ack_lo++;
        if (ctl.ack && !ack_prev) ack_rise = cyc;
        ack_prev = ctl.ack;
    end

    // core array stand-in: results ready a few cycles after core_stop
    initial begin
        res_start = 1'b0;
        forever begin
            @(negedge clk);
            if (core_stop) begin
                repeat (3) @(posedge clk);
                #1 res_start = 1'b1;
                @(posedge clk);
                #1 res_start = 1'b0;
            end
        end
    end

    initial begin
        out_wdata = '0;
        forever begin
            @(posedge clk);
            #1 out_wdata = out_wdata + 16'h0123;
        end
    end

    task automatic clear_log();
        net_log.delete(); in_log.delete(); wa_log.delete();
        wd_log.delete();  wx_log.delete(); breg_idx.delete();
        cv_n = 0; cs_n = 0; stop_n = 0; ack_lo = 0; wd_viol = 0; last_we = 0; ack_rise = 0;
    endtask

    task automatic start_op(input bit be, input int tin, input int tout, input int bat,
                            input int ioff, input int ooff, input int noff);
        @(posedge clk); #1;
        ctl.bias_en    = be;
        ctl.total_in   = DEF_LWIDTH'(tin);
        ctl.total_out  = DEF_LWIDTH'(tout);
        ctl.batch      = DEF_BWIDTH'(bat);
        ctl.in_offset  = DEF_IMGSIZE'(ioff);
        ctl.out_offset = DEF_IMGSIZE'(ooff);
        ctl.net_offset = DEF_NETSIZE'(noff);
        ctl.req        = 1'b1;
        @(posedge clk); #1;
        ctl.req        = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 2000; c++) begin
            if (ctl.ack) break;
            @(posedge clk); #1;
        end
        check(tag, ctl.ack, 1);
        @(negedge clk); #1;
    endtask

    initial begin
        int nw;
        rst = 1'b1; ctl.req = 1'b0; ctl.bias_en = 1'b0; ctl.total_in = '0; ctl.total_out = '0;
        ctl.batch = '0; ctl.in_offset = '0; ctl.out_offset = '0; ctl.net_offset = '0;
        net_we = 1'b0; net_sel = '0; net_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", ctl.ack, 1);
        check("rst_core_valid", core_valid, 0);
        check("rst_core_start", core_start, 0);
        check("rst_img_we", img_we, 0);
        check("rst_serial_we", serial_we, 0);
        check("rst_breg_we", breg_we, 0);
        check("rst_mem_net_we", mem_net_we, 0);
        check("rst_img_addr", img_addr, 0);
        @(posedge clk); #1 rst = 1'b0;

        // single group with bias
        clear_log();
        start_op(1, 4, 16, 1, 'h100, 'h200, 0);
        wait_done("t1_done");
        check_list("t1_net", net_log, ramp(0, 5, 1, 0));
        check_list("t1_in", in_log, ramp('h100, 4, 1, 0));
        check_list("t1_breg", breg_idx, ramp(5, 1, 1, 0));
        check("t1_stop", stop_n, 1);
        check("t1_start", cs_n, 1);
        check_list("t1_wr", wa_log, ramp('h200, 16, 1, 0));
        check_list("t1_wdata", wd_log, wx_log);
        check("t1_wdata_idle", wd_viol, 0);
        check("t1_ack_delay", ack_rise - last_we, 1);

        // partial second group
        clear_log();
        start_op(1, 4, 20, 1, 'h040, 'h300, 'h10);
        wait_done("t2_done");
        check_list("t2_net", net_log, ramp('h10, 5, 2, 5));
        check_list("t2_in", in_log, ramp('h040, 4, 2, 0));
        check_list("t2_breg", breg_idx, ramp(5, 1, 2, 5));
        check("t2_start", cs_n, 2);
        check_list("t2_wr", wa_log, ramp('h300, 20, 1, 0));
        check("t2_wdata_idle", wd_viol, 0);

        // batch of three, no bias
        clear_log();
        start_op(0, 8, 16, 3, 0, 0, 0);
        wait_done("t3_done");
        check_list("t3_net", net_log, ramp(0, 8, 3, 0));
        check_list("t3_in", in_log, ramp(0, 8, 3, 8));
        check_list("t3_wr", wa_log, ramp(0, 16, 3, 16));
        check_list("t3_breg", breg_idx, ramp(0, 0, 1, 0));
        check("t3_stop", stop_n, 3);
        check("t3_start", cs_n, 3);

        // empty jobs
        for (int z = 0; z < 3; z++) begin
            clear_log();
            start_op(0, (z == 1) ? 0 : 4, (z == 0) ? 0 : 16, (z == 2) ? 0 : 1, 0, 0, 0);
            wait_done("t4_done");
            check("t4_ack_low", ack_lo, 1);
            check("t4_writes", wa_log.size(), 0);
            check("t4_core_valid", cv_n, 0);
        end

        // reset during the fifth output write
        clear_log();
        start_op(1, 4, 16, 1, 'h100, 'h200, 0);
        nw = 0;
        for (int c = 0; c < 500 && nw < 5; c++) begin
            @(posedge clk); #1;
            if (img_we) nw++;
        end
        check("t5_reach_5th", nw, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_img_we", img_we, 0);
        check("t5_ack", ctl.ack, 1);
        check("t5_core_valid", core_valid, 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_list("t5_wr", wa_log, ramp('h200, 5, 1, 0));
        check("t5_ack_idle", ctl.ack, 1);

        // host weight write during the weight phase
        clear_log();
        start_op(1, 4, 16, 1, 'h100, 'h200, 0);
        for (int c = 0; c < 100; c++) begin
            if (core_valid) break;
            @(posedge clk); #1;
        end
        check("t6_in_weight", core_valid, 1);
        net_we = 1'b1; net_sel = 4'd3; net_addr = 14'h2AB;
        @(negedge clk);
        check("t6_mem_net_we", mem_net_we, 32'h0008);
        check("t6_mem_net_addr", mem_net_addr, 32'h2AB);
        @(posedge clk); #1;
        net_we = 1'b0;
        wait_done("t6_done");
        check_list("t6_net", net_log, ramp(1, 4, 1, 0));
        check_list("t6_breg", breg_idx, ramp(5, 1, 1, 0));
        check_list("t6_wr", wa_log, ramp('h200, 16, 1, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary: %0d run %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
